// File: rtl/add64_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add64_seq_ctrl (with sub-modules fullAdd1, fullAdd64)
// Brief    : Valid/ready issue/capture stage around a combinational 64-bit
//            ripple-carry adder. Operands are registered onto the adder,
//            held for SETTLE_CYCLES cycles (multi-cycle ripple path), then
//            sum and flags are captured and offered downstream.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// One-bit full adder cell.
// ----------------------------------------------------------------------------
module fullAdd1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    // Sum and majority carry of three inputs
    always_comb begin
        o_s = i_a ^ i_b ^ i_c;
        o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    end
endmodule

// ----------------------------------------------------------------------------
// 64-bit ripple-carry adder built from a chain of fullAdd1 cells. The carry
// ripples through all 64 cells, which is why the controller treats it as a
// multi-cycle path.
// ----------------------------------------------------------------------------
module fullAdd64 (
    input  logic [63:0] i_x,
    input  logic [63:0] i_y,
    input  logic        i_cIn,
    output logic [63:0] o_sum,
    output logic        o_cOut
);
    logic [64:0] w_carry;

    assign w_carry[0] = i_cIn;
    assign o_cOut     = w_carry[64];

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_bit
            fullAdd1 u_cell (
                .i_a (i_x[gi]),
                .i_b (i_y[gi]),
                .i_c (w_carry[gi]),
                .o_s (o_sum[gi]),
                .o_c (w_carry[gi+1])
            );
        end
    endgenerate
endmodule

// ----------------------------------------------------------------------------
// Issue/settle/capture controller.
// SETTLE_CYCLES: cycles the operands sit on the adder before capture (1..15).
// ----------------------------------------------------------------------------
module add64_seq_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    // operand side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic [1:0]  in_op,
    input  logic        in_carry,
    // result side
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic        out_carry,
    output logic        out_ovf,
    output logic        out_zero,
    output logic        out_neg
);
    // Counter is 4 bits wide: enough for the largest legal settle time.
    localparam logic [3:0] c_cntInit = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_settleCnt;

    // Operand registers feeding the adder directly; frozen during SETTLE.
    logic [63:0] r_x;
    logic [63:0] r_y;
    logic        r_cIn;

    // Captured result
    logic [63:0] r_sum;
    logic        r_carry;
    logic        r_ovf;
    logic        r_zero;
    logic        r_neg;
    logic        r_outValid;

    // Adder outputs and decoded next operands
    logic [63:0] w_sum;
    logic        w_cOut;
    logic        w_ovf;
    logic [63:0] w_yNext;
    logic        w_cInNext;
    logic        w_accept;
    logic        w_retire;

    fullAdd64 u_adder (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_cIn  (r_cIn),
        .o_sum  (w_sum),
        .o_cOut (w_cOut)
    );

    // Operand mapping: op[1] selects subtract (invert B), op[0] selects the
    // external carry; plain ADD/SUB use the implied carry 0/1.
    always_comb begin
        w_yNext   = in_op[1] ? ~in_b : in_b;
        w_cInNext = in_op[0] ? in_carry : in_op[1];
    end

    // Signed overflow: both addends share a sign that the sum does not.
    always_comb begin
        w_ovf = (r_x[63] == r_y[63]) && (w_sum[63] != r_x[63]);
    end

    // Handshakes; in DONE the ready path is combinational from out_ready so a
    // retire and a new accept can share one edge.
    always_comb begin
        in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
        w_accept = in_valid && in_ready;
        w_retire = r_outValid && out_ready;
    end

    // Controller state, settle counter, operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_settleCnt <= 4'd0;
            r_x         <= 64'd0;
            r_y         <= 64'd0;
            r_cIn       <= 1'b0;
            r_sum       <= 64'd0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_outValid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x         <= in_a;
                        r_y         <= w_yNext;
                        r_cIn       <= w_cInNext;
                        r_settleCnt <= c_cntInit;
                        r_state     <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (r_settleCnt == 4'd0) begin
                        r_sum      <= w_sum;
                        r_carry    <= w_cOut;
                        r_ovf      <= w_ovf;
                        r_zero     <= ~|w_sum;
                        r_neg      <= w_sum[63];
                        r_outValid <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_settleCnt <= r_settleCnt - 4'd1;
                    end
                end

                ST_DONE: begin
                    if (w_retire) begin
                        r_outValid <= 1'b0;
                        if (in_valid) begin
                            r_x         <= in_a;
                            r_y         <= w_yNext;
                            r_cIn       <= w_cInNext;
                            r_settleCnt <= c_cntInit;
                            r_state     <= ST_SETTLE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs
    always_comb begin
        out_valid = r_outValid;
        out_sum   = r_sum;
        out_carry = r_carry;
        out_ovf   = r_ovf;
        out_zero  = r_zero;
        out_neg   = r_neg;
    end
endmodule
`default_nettype wire

// File: tb/tb_add64_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_add64_seq_ctrl
// Brief    : Scoreboard bench for add64_seq_ctrl: expected results are queued
//            at accept time from an arithmetic reference model and compared
//            by an independent monitor whenever a result is retired.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add64_seq_ctrl;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [1:0]  in_op;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;
    logic        out_neg;

    // {sum, carry, ovf, zero, neg}
    logic [67:0] expQ[$];
    int          retireCyc[$];
    int          cyc = 0;
    int          nChecks = 0;
    int          nFails = 0;
    logic        randReady = 1'b0;

    add64_seq_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [67:0] act, input logic [67:0] exp);
        nChecks++;
        if (!ok) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op, input logic c);
        logic [63:0]        s;
        logic               co;
        logic signed [65:0] trueVal;
        logic               ov;
        logic               cin;
        cin = op[0] ? c : op[1];
        if (!op[1]) begin
            s       = a + b + 64'(cin);
            co      = ({1'b0, a} + {1'b0, b} + 65'(cin)) > 65'h0_FFFF_FFFF_FFFF_FFFF;
            trueVal = 66'(signed'(a)) + 66'(signed'(b)) + 66'(cin);
        end else begin
            // borrow-in is the complement of carry-in; carry-out = no borrow
            s       = a - b - 64'(!cin);
            co      = {1'b0, a} >= ({1'b0, b} + 65'(!cin));
            trueVal = 66'(signed'(a)) - 66'(signed'(b)) - 66'(!cin);
        end
        ov = (trueVal > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (trueVal < -66'sh0_8000_0000_0000_0000);
        return {s, co, ov, (s == 64'd0), s[63]};
    endfunction

    // Monitor: compare every retired result against the queue head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                chk(1'b0, "unexpected_result", {out_sum, out_carry, out_ovf, out_zero, out_neg}, 68'd0);
            end else begin
                logic [67:0] e;
                e = expQ.pop_front();
                chk({out_sum, out_carry, out_ovf, out_zero, out_neg} === e, "result",
                    {out_sum, out_carry, out_ovf, out_zero, out_neg}, e);
            end
            retireCyc.push_back(cyc);
        end
    end

    // Random downstream backpressure while enabled
    always @(posedge clk) begin
        if (randReady) #1 out_ready = ($urandom_range(0, 3) != 0);
    end

    // Issue one operation; pushes the expectation at the accepting edge
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op, input logic c);
        bit acc = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_carry = c;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                expQ.push_back(model(a, b, op, c));
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) chk(1'b0, "accept_timeout", 68'd0, 68'd1);
    endtask

    // Edges from accept (already passed) until out_valid is seen high
    task automatic measureLatency();
        int edges = 1;
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin @(posedge clk); edges++; end
        end
        chk(seen && edges == SETTLE + 1, "latency", 68'(edges), 68'(SETTLE + 1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 400 && expQ.size() > 0; n++) @(posedge clk);
        #1;
        chk(expQ.size() == 0, "drain", 68'(expQ.size()), 68'd0);
    endtask

    task automatic directed(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op, input logic c);
        out_ready = 1'b0;
        issue(a, b, op, c);
        measureLatency();
        drain();
    endtask

    initial begin
        logic [63:0] held;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_carry = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk({in_ready, out_valid} == 2'b10, "reset_handshake", 68'({in_ready, out_valid}), 68'b10);
        chk({out_sum, out_carry, out_ovf, out_zero, out_neg} == 68'd0, "reset_outputs",
            {out_sum, out_carry, out_ovf, out_zero, out_neg}, 68'd0);
        @(posedge clk); #1;

        // Reset mid-SETTLE discards the operation
        issue(64'd5, 64'd7, 2'b00, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        @(negedge clk);
        chk({in_ready, out_valid} == 2'b10, "rst_mid_settle_hs", 68'({in_ready, out_valid}), 68'b10);
        chk(out_sum == 64'd0, "rst_mid_settle_sum", 68'(out_sum), 68'd0);
        @(posedge clk); #1;
        directed(64'd1, 64'd1, 2'b00, 1'b0);

        // Boundary cases: wrap, signed overflow, borrow, carry chaining
        directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0);
        directed(64'h8000_0000_0000_0000, 64'd1, 2'b10, 1'b0);
        directed(64'd3, 64'd5, 2'b10, 1'b0);
        directed(64'h0000_0000_FFFF_FFFF, 64'd0, 2'b01, 1'b1);
        directed(64'd10, 64'd3, 2'b11, 1'b0);
        directed(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0);

        // Backpressure: result held, pending beat not consumed
        out_ready = 1'b0;
        issue(64'd100, 64'd23, 2'b00, 1'b0);
        for (int n = 0; n < 40 && !out_valid; n++) begin @(negedge clk); end
        held = out_sum;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 64'd9; in_b = 64'd4; in_op = 2'b10; in_carry = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk(out_valid && !in_ready && out_sum == held, "backpressure_hold",
                {out_sum, 1'b0, out_valid, in_ready, 1'b0}, {held, 4'b0100});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        expQ.push_back(model(64'd9, 64'd4, 2'b10, 1'b0));
        @(negedge clk);
        chk(in_ready && out_valid, "retire_and_accept", 68'({in_ready, out_valid}), 68'b11);
        @(posedge clk); #1;
        in_valid = 1'b0;
        measureLatency();
        drain();

        // Back-to-back stream with out_ready held high
        retireCyc.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) issue(64'(2 * k + 1), 64'(2 * k + 2), 2'b00, 1'b0);
        drain();
        for (int k = 1; k < retireCyc.size(); k++)
            chk(retireCyc[k] - retireCyc[k-1] == SETTLE + 1, "stream_spacing",
                68'(retireCyc[k] - retireCyc[k-1]), 68'(SETTLE + 1));
        chk(retireCyc.size() == 4, "stream_count", 68'(retireCyc.size()), 68'd4);

        // Randomized operations with random backpressure
        randReady = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: rb = ra;
                default: ;
            endcase
            issue(ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        randReady = 1'b0;
        @(posedge clk); #2;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
